// File: rtl/id_ex_register_pkg.sv
// Shared CPU definitions: register-number width, control-bit bundle,
// ALU opcode encodings and the saturating stall-counter helper.
package id_ex_register_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 6;
  localparam int ALUOP_W    = 4;
  localparam int CNT_W      = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_SLT = 4'h4,
    ALU_NOR = 4'h5,
    ALU_XOR = 4'h6,
    ALU_SLL = 4'h7
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Counter increments only when enabled and never wraps past CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic              en);
    logic [CNT_W-1:0] result;
    if (en && (value != CNT_MAX)) begin
      result = value + 16'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/id_ex_register_load_use_detector.sv
// Purely combinational load-use hazard check between the load in EX and
// the instruction currently decoded in ID.
module load_use_detector
  import id_ex_register_pkg::*;
(
  input  logic      ex_mem_read_i,
  input  reg_addr_t ex_rt_i,
  input  reg_addr_t id_rs_i,
  input  reg_addr_t id_rt_i,
  output logic      hazard_o
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (ex_rt_i == id_rs_i);
  assign rt_match_s = (ex_rt_i == id_rt_i);

  // A load into $zero never produces a value anyone can depend on.
  assign hazard_o = ex_mem_read_i && (ex_rt_i != 5'd0) && (rs_match_s || rt_match_s);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on stall or flush, and a saturating count of stall cycles.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic [DATA_W-1:0]  id_data1,
  input  logic [DATA_W-1:0]  id_data2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc4,
  input  logic               id_regWrite,
  input  logic               id_memRead,
  input  logic               id_memWrite,
  input  logic               id_memToReg,
  input  logic               id_aluSrc,
  input  logic               id_regDst,
  input  logic [ALUOP_W-1:0] id_aluOp,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic [4:0]         ex_rd,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc4,
  output logic               ex_regWrite,
  output logic               ex_memRead,
  output logic               ex_memWrite,
  output logic               ex_memToReg,
  output logic               ex_aluSrc,
  output logic               ex_regDst,
  output logic [ALUOP_W-1:0] ex_aluOp,
  output logic               stall,
  output logic [15:0]        stall_count
);

  reg_addr_t           rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]   data1_q, data1_d, data2_q, data2_d;
  logic [DATA_W-1:0]   imm_q, imm_d, pc4_q, pc4_d;
  ctrl_t               ctrl_q, ctrl_d, id_ctrl_s;
  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;
  logic                hazard_s;
  logic                stall_s;
  logic                bubble_s;

  load_use_detector u_load_use_detector (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .hazard_o      (hazard_s)
  );

  // Flush wins: the branch squashes the ID instruction, so holding it is pointless.
  assign stall_s  = hazard_s && !flush;
  assign bubble_s = stall_s || flush;

  assign id_ctrl_s = '{id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst};

  always_comb begin
    rs_d    = id_rs;
    rt_d    = id_rt;
    rd_d    = id_rd;
    data1_d = id_data1;
    data2_d = id_data2;
    imm_d   = id_imm;
    pc4_d   = id_pc4;
    ctrl_d  = id_ctrl_s;
    aluop_d = id_aluOp;
    if (bubble_s) begin
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      rd_d    = 5'd0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      pc4_d   = '0;
      ctrl_d  = CTRL_NOP;
      aluop_d = '0;
    end else begin
      ctrl_d  = id_ctrl_s;
    end
    stall_count_d = sat_inc(stall_count_q, stall_s);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_q          <= 5'd0;
      rt_q          <= 5'd0;
      rd_q          <= 5'd0;
      data1_q       <= '0;
      data2_q       <= '0;
      imm_q         <= '0;
      pc4_q         <= '0;
      ctrl_q        <= CTRL_NOP;
      aluop_q       <= '0;
      stall_count_q <= 16'd0;
    end else begin
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rd_q          <= rd_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      imm_q         <= imm_d;
      pc4_q         <= pc4_d;
      ctrl_q        <= ctrl_d;
      aluop_q       <= aluop_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign ex_data1    = data1_q;
  assign ex_data2    = data2_q;
  assign ex_imm      = imm_q;
  assign ex_pc4      = pc4_q;
  assign ex_regWrite = ctrl_q.reg_write;
  assign ex_memRead  = ctrl_q.mem_read;
  assign ex_memWrite = ctrl_q.mem_write;
  assign ex_memToReg = ctrl_q.mem_to_reg;
  assign ex_aluSrc   = ctrl_q.alu_src;
  assign ex_regDst   = ctrl_q.reg_dst;
  assign ex_aluOp    = aluop_q;
  assign stall       = stall_s;
  assign stall_count = stall_count_q;

endmodule
